// File: rtl/fb_writer_pkg.sv
// fb_writer_pkg: shared types and status-word layout for fb_stream_writer
package fb_writer_pkg;
  typedef struct packed {
    logic        sof;
    logic [3:0]  be;
    logic [31:0] data;
  } fifo_entry_t;
  typedef enum logic {IDLE, WRITE} wr_state_t;
  localparam int RD_LEVEL_LSB = 0;
  localparam int RD_LEVEL_W   = 16;
  localparam int RD_FRAME_LSB = 16;
  localparam int RD_FRAME_W   = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty/level and a pop-loaded output word
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d, push_ok, pop_ok;
  logic [W-1:0]  dout_q, dout_d;
  always_comb begin
    push_ok = push & ~full_q;
    pop_ok  = pop & ~empty_q;
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    full_d  = level_d == LW'(DEPTH);
    empty_d = level_d == '0;
    dout_d  = pop_ok ? mem_q[rd_q] : dout_q;
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      dout_q  <= dout_d;
    end
  // Storage needs no reset: the pointers define which words are valid.
  always_ff @(posedge sys_clk)
    if (push_ok) mem_q[wr_q] <= din;
  assign head  = mem_q[rd_q];
  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;
endmodule

// File: rtl/fb_stream_writer.sv
// fb_stream_writer: Avalon-ST-style pixel push into a FIFO, drained as Avalon-MM writes to the framebuffer.
// Define FB_WRITER_SOF_EN to let writes with s_address[2]=1 queue start-of-frame markers.
module fb_stream_writer
  import fb_writer_pkg::*;
#(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] FB_BASE    = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic [3:0]  s_byteenable,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic        s_waitrequest,
  output logic [31:0] m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  output logic        frame_done
);
  localparam int NPIX = HDISP * VDISP;
  localparam int PW   = $clog2(NPIX);
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  fifo_entry_t   in_e, head_e, out_e;
  logic          full, empty, pop, accept, wrap, frame_done_q, frame_done_d;
  logic [LW-1:0] level;
  wr_state_t     state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          unused_ok;
`ifdef FB_WRITER_SOF_EN
  assign in_e = '{sof: s_address[2], be: s_byteenable, data: s_writedata};
`else
  assign in_e = '{sof: 1'b0, be: s_byteenable, data: s_writedata};
`endif
  sync_fifo #(.W($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .push(s_write), .din(in_e), .pop(pop),
    .head(head_e), .dout(out_e), .full(full), .empty(empty), .level(level)
  );
  always_comb begin
    accept       = state_q == WRITE && !m_waitrequest;
    wrap         = pix_cnt_q == PW'(NPIX - 1);
    pop          = !empty && (state_q == IDLE || accept);
    pix_cnt_d    = accept ? (wrap ? '0 : pix_cnt_q + 1'b1) : pix_cnt_q;
    frame_cnt_d  = frame_cnt_q + 16'(accept && wrap);
    frame_done_d = accept && wrap;
    state_d      = pop ? (head_e.sof ? IDLE : WRITE) : (accept ? IDLE : state_q);
    // A marker is consumed without a beat and restarts the frame address.
    if (pop && head_e.sof) pix_cnt_d = '0;
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  assign m_write       = state_q == WRITE;
  assign m_address     = FB_BASE + 32'({pix_cnt_q, 2'b00});
  assign m_writedata   = out_e.data;
  assign m_byteenable  = out_e.be;
  assign frame_done    = frame_done_q;
  assign s_waitrequest = s_write & full;
  assign s_readdata[RD_FRAME_LSB +: RD_FRAME_W] = frame_cnt_q;
  assign s_readdata[RD_LEVEL_LSB +: RD_LEVEL_W] = RD_LEVEL_W'(level);
  assign unused_ok = &{1'b0, s_address, s_read, head_e.be, head_e.data, out_e.sof};
endmodule
